// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_pkg
//  Description : Shared encodings for the RV32M divide/remainder unit:
//                operation codes, controller states and small op decoders.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    // Operation encodings as carried on the op field of the request
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // DIV and REM work on two's complement operands
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM and REMU return the remainder instead of the quotient
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Request/response bundle between the execute stage and the
//                divide unit.
//                master : drives start/op/a/b, observes busy/done/result
//                slave  : the divide unit itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/div_unit_cla.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_cla
//  Description : Execute-stage carry-lookahead adder/subtractor. Bits are
//                grouped by four; each group forms its own generate/propagate
//                and the group carries are chained between groups.
//                a, b    : operands
//                sub_en  : 1 -> a - b (invert b, carry-in 1)
//                sum     : result
//                cout    : carry out (1 = no borrow when subtracting)
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit_cla #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub_en,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NG = (WIDTH + 3) / 4;

    logic [WIDTH-1:0] w_bx;
    assign w_bx = sub_en ? ~b : b;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int LO = 4 * k;
        localparam int N  = ((WIDTH - LO) < 4) ? (WIDTH - LO) : 4;

        logic         cin;
        logic         grp_g;
        logic         grp_p;
        logic [N-1:0] gg;
        logic [N-1:0] pp;
        logic [N-1:0] cc;

        assign gg = a[LO +: N] & w_bx[LO +: N];
        assign pp = a[LO +: N] ^ w_bx[LO +: N];

        // cc[j] = G[j-1:0] | P[j-1:0] & cin, built up alongside the group terms
        always_comb begin
            cc    = '0;
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int j = 0; j < N; j++) begin
                cc[j] = grp_g | (grp_p & cin);
                grp_g = gg[j] | (pp[j] & grp_g);
                grp_p = grp_p & pp[j];
            end
        end

        assign sum[LO +: N] = pp ^ cc;

        if (k == 0) begin : g_head
            assign cin = sub_en;
        end else begin : g_link
            assign cin = g_grp[k-1].grp_g | (g_grp[k-1].grp_p & g_grp[k-1].cin);
        end
    end

    assign cout = g_grp[NG-1].grp_g | (g_grp[NG-1].grp_p & g_grp[NG-1].cin);

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
//                One quotient bit per cycle; the trial subtraction runs on
//                the shared CLA. Divide by zero bypasses the iteration.
//                clk, rst : clock, synchronous active-high reset
//                bus      : slave side of div_unit_if (start/op/a/b in,
//                           busy/done/result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int            CW           = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_COUNT_INIT = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_count;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_rem;

    logic             w_accept;
    logic             w_b_zero;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH:0]   w_trial;
    logic             w_no_borrow;
    logic             w_unused_trial_msb;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_final;
    logic [WIDTH-1:0] w_rem_final;

    // ---------------- operand conditioning ----------------
    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_b_zero = (bus.b == '0);
    assign w_signed = op_is_signed(bus.op);
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which read as unsigned is the right magnitude
    assign w_mag_a  = w_a_neg ? (-bus.a) : bus.a;
    assign w_mag_b  = w_b_neg ? (-bus.b) : bus.b;

    // ---------------- one restoring step ----------------
    // The quotient register holds the not-yet-consumed dividend bits in its
    // upper part, so shifting {rem, quo} feeds the next dividend bit into rem.
    assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};

    div_unit_cla #(
        .WIDTH (WIDTH + 1)
    ) u_cla (
        .a      (w_shift_rem),
        .b      ({1'b0, r_mag_b}),
        .sub_en (1'b1),
        .sum    (w_trial),
        .cout   (w_no_borrow)
    );

    // Whenever the trial is kept it is below mag_b, so its top bit is zero
    assign w_unused_trial_msb = w_trial[WIDTH];
    assign w_rem_next  = w_no_borrow ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_no_borrow};
    assign w_quo_final = r_neg_q ? (-w_quo_next) : w_quo_next;
    assign w_rem_final = r_neg_r ? (-w_rem_next) : w_rem_next;

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = w_b_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                bus.busy = 1'b1;
                if (r_count == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.busy     = 1'b1;
                bus.done     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_mag_b  <= '0;
            r_count  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_count  <= C_COUNT_INIT;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_is_rem <= op_is_rem(bus.op);
            if (w_b_zero) begin
                r_result <= op_is_rem(bus.op) ? bus.a : '1;
            end
        end else if (r_state == S_CALC) begin
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_count <= r_count - 1'b1;
            if (r_count == '0) begin
                r_result <= r_is_rem ? w_rem_final : w_quo_final;
            end
        end
    end

    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit: directed corner cases,
//                control-path cases and randomized ops against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;  // clock edges from driving start to seeing done

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M semantics in plain 64-bit arithmetic
    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb, ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (b == '0) return op[1] ? a : {W{1'b1}};
        case (op)
            2'b00:   res = sa / sb;
            2'b01:   res = ua / ub;
            2'b10:   res = sa % sb;
            default: res = ua % ub;
        endcase
        return res[W-1:0];
    endfunction

    // Drives one request starting at the current negedge and waits for done.
    // hold     : keep start high throughout (and on return)
    // pulse_at : edge count at which a spurious one-cycle start is issued
    // pre_edges: edges expected before acceptance (start raised during DONE)
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hold, input int pulse_at,
                          input int pre_edges);
        logic [W-1:0] exp_res;
        int           exp_edges;
        int           edges;
        bit           seen;
        exp_res   = model(op, a, b);
        exp_edges = pre_edges + ((b == '0) ? 1 : LAT);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        edges     = 0;
        seen      = 1'b0;
        while (!seen && edges < 200) begin
            @(negedge clk);
            edges++;
            if (bus.done) seen = 1'b1;
            if (pre_edges > 0 && edges == pre_edges)
                check_eq({tag, "_idle_gap"}, W'(bus.busy), W'(0));
            if (edges == pre_edges + 1)
                check_eq({tag, "_busy"}, W'(bus.busy), W'(1));
            if (edges > pre_edges) begin
                bus.a = $urandom;
                bus.b = $urandom;
                if (!hold) bus.start = (edges == pulse_at);
                if (edges == pulse_at) bus.op = 2'($urandom_range(0, 3));
            end
        end
        check_eq({tag, "_done_seen"}, W'(seen), W'(1));
        check_eq({tag, "_res"}, bus.result, exp_res);
        // cycles counted inclusive of the cycle start was raised in
        check_eq({tag, "_cycles"}, W'(edges + 1), W'(exp_edges + 1));
        check_eq({tag, "_busy_at_done"}, W'(bus.busy), W'(1));
        if (!hold) begin
            @(negedge clk);
            check_eq({tag, "_busy_after"}, W'(bus.busy), W'(0));
            check_eq({tag, "_done_after"}, W'(bus.done), W'(0));
        end
    endtask

    initial begin
        int          n_done;
        logic [1:0]  rop;
        logic [W-1:0] ra, rb;
        int          kind;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", W'(bus.busy), W'(0));
        check_eq("rst_done", W'(bus.done), W'(0));
        check_eq("rst_result", bus.result, W'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, -1, 0);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 1'b0, -1, 0);
        run_op("div_m7_2",   OP_DIV,  -32'sd7, 32'd2, 1'b0, -1, 0);
        run_op("rem_m7_2",   OP_REM,  -32'sd7, 32'd2, 1'b0, -1, 0);
        run_op("div_7_m2",   OP_DIV,  32'd7, -32'sd2, 1'b0, -1, 0);
        run_op("rem_7_m2",   OP_REM,  32'd7, -32'sd2, 1'b0, -1, 0);
        run_op("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 1'b0, -1, 0);
        run_op("rem_5_0",    OP_REM,  32'd5, 32'd0, 1'b0, -1, 0);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 0);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 0);

        // Control: spurious start in CALC, then start held across two ops
        run_op("pulse_calc", OP_DIVU, 32'd1000, 32'd10, 1'b0, 5, 0);
        run_op("hold_1", OP_DIVU, 32'd50, 32'd5, 1'b1, -1, 0);
        run_op("hold_2", OP_REMU, 32'd50, 32'd6, 1'b1, -1, 1);
        bus.start = 1'b0;
        @(negedge clk);
        check_eq("hold_end_busy", W'(bus.busy), W'(0));

        // Reset in the middle of CALC
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd12345;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_busy", W'(bus.busy), W'(0));
        check_eq("midrst_done", W'(bus.done), W'(0));
        check_eq("midrst_result", bus.result, W'(0));
        rst    = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check_eq("midrst_no_done", W'(n_done), W'(0));
        run_op("after_rst", OP_DIV, -32'sd1000, 32'd7, 1'b0, -1, 0);

        // Randomized ops, biased toward the boundary operands
        for (int i = 0; i < 1000; i++) begin
            rop  = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 9);
            ra   = $urandom;
            rb   = $urandom;
            case (kind)
                0:       rb = '0;
                1:       begin ra = 32'h8000_0000; rb = '1; end
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = -32'($urandom_range(1, 15));
                4:       ra = 32'($urandom_range(0, 20));
                default: ;
            endcase
            run_op("rand", rop, ra, rb, 1'b0, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
